// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron datapath: widths, FSM states and
// the saturating clamp used wherever a signed accumulator drives a current.
package snn_pkg;

  localparam int CURRENT_W = 5;
  localparam int WEIGHT_W  = 4;
  localparam int ACC_W     = 9;
  localparam int SUM_W     = 8;

  typedef enum logic {
    ST_INTEGRATE = 1'b0,
    ST_REFRACT   = 1'b1
  } state_e;

  // Negative values floor at 0, values above the current range pin at max.
  function automatic logic [CURRENT_W-1:0] clamp_u(input logic signed [ACC_W-1:0] v);
    logic [CURRENT_W-1:0] r;
    if (v[ACC_W-1])
      r = '0;
    else if (|v[ACC_W-2:CURRENT_W])
      r = '1;
    else
      r = v[CURRENT_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/synapse_weight_file.sv
// Per-line synaptic weights {inh, w} with a synchronous write port. Sums are
// formed from the registered weights, so a write lands only after the edge.
module synapse_weight_file
  import snn_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [$clog2(N_IN)-1:0]  cfg_addr,
  input  logic [WEIGHT_W:0]        cfg_wdata,
  input  logic [N_IN-1:0]          spike,
  output logic [SUM_W-1:0]         exc_sum,
  output logic [SUM_W-1:0]         inh_sum
);

  localparam int AW = $clog2(N_IN);

  logic [WEIGHT_W:0] w_q [N_IN];
  logic [WEIGHT_W:0] w_d [N_IN];

  // Address decode for the write strobe.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      w_d[i] = w_q[i];
      if (cfg_we && (cfg_addr == AW'(i)))
        w_d[i] = cfg_wdata;
    end
  end

  // Weight registers, cleared by reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_IN; i++) begin
      if (reset)
        w_q[i] <= '0;
      else
        w_q[i] <= w_d[i];
    end
  end

  // Split the weights of the active lines into excitatory and inhibitory sums.
  always_comb begin
    exc_sum = '0;
    inh_sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (spike[i]) begin
        if (w_q[i][WEIGHT_W])
          inh_sum = inh_sum + SUM_W'(w_q[i][WEIGHT_W-1:0]);
        else
          exc_sum = exc_sum + SUM_W'(w_q[i][WEIGHT_W-1:0]);
      end
    end
  end

endmodule

// File: rtl/synapse_driver.sv
// Presynaptic front end: weighted spike summation into a leaky, clamped
// current, with a refractory window triggered by the driven neuron's spike.
//
// state        | meaning
// ST_INTEGRATE | current = clamp((current >> LEAK_SHIFT) + exc - inh)
// ST_REFRACT   | current held at 0, spikes dropped, post_spike ignored;
//              | counter reaching 0 resumes integration on that same edge
module synapse_driver
  import snn_pkg::*;
#(
  parameter int N_IN           = 4,
  parameter int LEAK_SHIFT     = 1,
  parameter int REFRACT_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_IN-1:0]          spike_in,
  input  logic                     post_spike,
  input  logic                     cfg_we,
  input  logic [$clog2(N_IN)-1:0]  cfg_addr,
  input  logic [WEIGHT_W:0]        cfg_wdata,
  output logic [CURRENT_W-1:0]     current_out,
  output logic                     refractory,
  output logic [7:0]               drop_count
);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [CURRENT_W-1:0]   cur_q, cur_d;
  logic [7:0]             drop_q, drop_d;
  logic [SUM_W-1:0]       exc_sum, inh_sum;
  logic [CURRENT_W-1:0]   leak;
  logic signed [ACC_W-1:0] acc;
  logic                   discard;

  synapse_weight_file #(.N_IN(N_IN)) u_weights (
    .clk      (clk),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .spike    (spike_in),
    .exc_sum  (exc_sum),
    .inh_sum  (inh_sum)
  );

  // Leaky accumulate at 9-bit width; cur_q is 0 in REFRACT, so the same
  // expression restarts integration from 0 on the exit edge.
  assign leak = cur_q >> LEAK_SHIFT;
  assign acc  = {{(ACC_W-CURRENT_W){1'b0}}, leak} + {1'b0, exc_sum} - {1'b0, inh_sum};

  // Next-state, current and drop-count logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    discard = 1'b0;
    case (state_q)
      ST_INTEGRATE: begin
        if (post_spike) begin
          state_d = ST_REFRACT;
          cnt_d   = 4'(REFRACT_CYCLES - 1);
          cur_d   = '0;
          discard = 1'b1;
        end else begin
          cur_d = clamp_u(acc);
        end
      end
      ST_REFRACT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_INTEGRATE;
          cur_d   = clamp_u(acc);
        end else begin
          cnt_d   = cnt_q - 4'd1;
          cur_d   = '0;
          discard = 1'b1;
        end
      end
      default: begin
        state_d = ST_INTEGRATE;
        cur_d   = '0;
      end
    endcase

    drop_d = drop_q;
    if (discard && (|spike_in) && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INTEGRATE;
      cnt_q   <= '0;
      cur_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      drop_q  <= drop_d;
    end
  end

  assign current_out = cur_q;
  assign refractory  = (state_q == ST_REFRACT);
  assign drop_count  = drop_q;

endmodule

// File: doc/synapse_driver.md
# synapse_driver

Presynaptic front end for the `lif` neuron. It turns up to `N_IN` incoming spike lines into the 5-bit input current the neuron integrates. Each line has a programmable weight, either excitatory or inhibitory. The block keeps a leaky synaptic current and enforces a refractory window after each postsynaptic spike. It sits between the spike fabric, or an upstream neuron's `spike`, and a neuron's `current` input, and it closes the loop by consuming that neuron's `spike` as `post_spike`.

## Interface
- `N_IN`, default 4: number of presynaptic spike inputs, legal range 2..8.
- `LEAK_SHIFT`, default 1: right-shift applied to the held current each cycle.
- `REFRACT_CYCLES`, default 3: length of the refractory window in cycles, legal range 1..15.
- Ports:
  - `clk`  in  1  single clock; all logic on the rising edge.
  - `reset`  in  1  synchronous, active-high reset.
  - `spike_in`  in  N_IN  presynaptic spike lines, sampled every cycle.
  - `post_spike`  in  1  spike from the driven neuron; starts the refractory window.
  - `cfg_we`  in  1  weight write strobe.
  - `cfg_addr`  in  clog2(N_IN)  index of the weight being written.
  - `cfg_wdata`  in  5  `{inh, w[3:0]}`; `inh`=1 makes the weight inhibitory.
  - `current_out`  out  5  registered synaptic current, feeds the neuron's `current`.
  - `refractory`  out  1  high while in the REFRACT state.
  - `drop_count`  out  8  saturating count of cycles on which spikes were discarded.

## Operation
- Weight file: `N_IN` entries of 5 bits each. Reset clears every entry to 0.
  - When `cfg_we` is high, the addressed entry is written at the clock edge.
  - Spikes sampled in the same cycle as a write use the old weight.
- FSM has two states: INTEGRATE (entered on reset) and REFRACT.
- INTEGRATE, when `post_spike`=0:
  - exc = sum of `w` over asserted lines with `inh`=0.
  - inh = sum of `w` over asserted lines with `inh`=1.
  - next = (current_out >> LEAK_SHIFT) + exc − inh.
  - Evaluate at 9-bit signed width, then clamp to the range [0, 31].
- INTEGRATE, when `post_spike`=1:
  - `current_out` goes to 0 and the FSM moves to REFRACT.
  - The refractory counter loads REFRACT_CYCLES−1.
  - Any spikes on `spike_in` that cycle are discarded and counted.
- REFRACT:
  - `current_out` is held at 0 and all `spike_in` values are discarded.
  - `post_spike` is ignored.
  - The counter decrements each cycle. On the cycle it reads 0, the next state is INTEGRATE.
- `drop_count` increments by 1 on any cycle where |spike_in is true and the spikes are discarded. It saturates at 255.
- `cfg_we` is honoured in every state.
- Reset, including in the middle of REFRACT: FSM returns to INTEGRATE, and `current_out`, `refractory`, `drop_count`, the counter and all weights go to 0.

## Timing
- Every output is registered, and every output is 0 during reset and in the cycle after reset deasserts.
- Latency: `spike_in` sampled at edge t is reflected in `current_out` after edge t, i.e. one cycle.
- Refractory window: with `post_spike` high at edge t:
  - `refractory` is high and `current_out`=0 for exactly REFRACT_CYCLES cycles, starting after edge t.
  - Integration restarts from 0 using the spikes sampled at edge t+REFRACT_CYCLES.
- Priority: `reset` > `post_spike` > integration. A weight write and its use in the same cycle resolve to the old weight.

## Structure
- A shared package `snn_pkg` holds:
  - `CURRENT_W`=5, `WEIGHT_W`=4;
  - the FSM state enum {ST_INTEGRATE, ST_REFRACT};
  - the clamp-to-unsigned helper function, so the `lif` path and future synapses saturate identically.
- One natural sub-module, `synapse_weight_file`: the `N_IN`×5 register file with its synchronous write port. It outputs separate excitatory and inhibitory sums for a given spike vector.
- The top level holds the FSM, the refractory counter, the leak/clamp datapath and the drop counter.

## Test plan
All scenarios use N_IN=4, LEAK_SHIFT=1, REFRACT_CYCLES=3.
- Reset: hold `reset` 2 cycles with random inputs → `current_out`=0, `refractory`=0, `drop_count`=0. Then with all weights 0, `spike_in`=4'b1111 → `current_out` stays 0.
- Leak: write w0={0,6}, pulse `spike_in`=4'b0001 for one cycle → `current_out` is 6, 3, 1, 0, 0 on successive cycles.
- Saturation and write ordering:
  - Write all weights={0,15}, hold `spike_in`=4'b1111 → `current_out`=31 and it stays 31.
  - Write w0={0,2} while `spike_in`[0]=1 → that cycle still adds 15.
- Inhibition:
  - w1={1,10}, `current_out`=31, `spike_in`=4'b0010 → next value 5.
  - From `current_out`=4 with the same input → next value 0, clamped rather than wrapping.
- Refractory:
  - With `current_out`=20, assert `post_spike` together with `spike_in`=4'b0001 → `refractory`=1 and `current_out`=0 for 3 cycles.
  - Holding `spike_in`=4'b0001 throughout → `drop_count`=3, then integration resumes and gives 6.
  - A second `post_spike` inside the window has no effect.
- Reset mid-refractory: assert `reset` in the 2nd REFRACT cycle → next cycle `refractory`=0, all weights 0 (a spike now yields 0), `drop_count`=0.
